// File: rtl/conv_sched.sv
// conv_sched: control sequencer for the single-lane convolution datapath.
//
// Loads one frame of LENX samples into the x RAM. Then, for each of the
// NOUT = LENX-LENF+1 output windows, it issues x/f read addresses and drives
// the accumulator clear/enable strobes. Each result is then offered
// downstream. Memories, multiplier, saturation and ReLU live outside this
// block and only follow its strobes.
//
// Handshake rule (both ports): a transfer happens on a rising edge where
// valid && ready are both 1. Valid, once raised, is held with its payload
// stable until the transfer. Neither side may make valid depend
// combinationally on ready. s_ready_x depends only on state. m_valid_y
// depends only on state.
//
// fsm_state exposes the sequencer state for observation:
// 0 = LOAD, 1 = COMPUTE, 2 = DRAIN, 3 = OUT.
module conv_sched #(
    parameter int LENX  = 64,
    parameter int LENF  = 33,
    parameter int ADDRX = 6,
    parameter int ADDRF = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid_x,
    output logic             s_ready_x,
    output logic             m_valid_y,
    input  logic             m_ready_y,
    output logic             wr_en_x,
    output logic [ADDRX-1:0] addr_x,
    output logic [ADDRF-1:0] addr_f,
    output logic             clr_acc,
    output logic             en_acc,
    output logic [1:0]       fsm_state
);

    localparam int NOUT = LENX - LENF + 1;

    // Terminal counts, sized to the counters they are compared against.
    localparam logic [ADDRX:0]   WC_LAST = (ADDRX+1)'(LENX - 1);
    localparam logic [ADDRF:0]   K_LAST  = (ADDRF+1)'(LENF - 1);
    localparam logic [ADDRX-1:0] W_LAST  = ADDRX'(NOUT - 1);
    localparam logic [ADDRX:0]   WC_ONE  = (ADDRX+1)'(1);
    localparam logic [ADDRF:0]   K_ONE   = (ADDRF+1)'(1);
    localparam logic [ADDRX-1:0] W_ONE   = ADDRX'(1);

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2,
        OUT     = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [ADDRX:0]   wc;        // write counter during LOAD
    logic [ADDRX:0]   wc_nxt;
    logic [ADDRF:0]   k;         // tap index inside the current window
    logic [ADDRF:0]   k_nxt;
    logic [ADDRX-1:0] w;         // current output window
    logic [ADDRX-1:0] w_nxt;
    logic             en_q;      // read issued last cycle, data arrives now
    logic [ADDRX:0]   rd_addr;   // w + k, one bit wider so no silent wrap
    logic             load_hs;
    logic             out_hs;

    // Handshake qualifiers; the other port's signals are ignored in other states.
    assign load_hs = s_valid_x && (state == LOAD);
    assign out_hs  = m_ready_y && (state == OUT);

    // Window read address. w + k never exceeds LENX-1, so the low bits are exact.
    assign rd_addr = {1'b0, w} + (ADDRX+1)'(k);

    // State and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LOAD;
            wc    <= '0;
            k     <= '0;
            w     <= '0;
        end else begin
            state <= state_nxt;
            wc    <= wc_nxt;
            k     <= k_nxt;
            w     <= w_nxt;
        end
    end

    // Accumulate enable trails each issued read by the 1-cycle memory latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q <= 1'b0;
        end else begin
            en_q <= (state == COMPUTE);
        end
    end

    // Next-state and counter update. k is held at its last value through DRAIN
    // and OUT, so the read address stays frozen while a result waits.
    always_comb begin
        state_nxt = state;
        wc_nxt    = wc;
        k_nxt     = k;
        w_nxt     = w;
        case (state)
            LOAD: begin
                if (load_hs) begin
                    if (wc == WC_LAST) begin
                        state_nxt = COMPUTE;
                        wc_nxt    = '0;
                        w_nxt     = '0;
                        k_nxt     = '0;
                    end else begin
                        wc_nxt = wc + WC_ONE;
                    end
                end
            end
            COMPUTE: begin
                if (k == K_LAST) begin
                    state_nxt = DRAIN;
                end else begin
                    k_nxt = k + K_ONE;
                end
            end
            DRAIN: begin
                state_nxt = OUT;
            end
            OUT: begin
                if (out_hs) begin
                    k_nxt = '0;
                    if (w == W_LAST) begin
                        state_nxt = LOAD;
                        wc_nxt    = '0;
                        w_nxt     = '0;
                    end else begin
                        state_nxt = COMPUTE;
                        w_nxt     = w + W_ONE;
                    end
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    // Output decode. The addresses are the write counter in LOAD and the
    // window read address otherwise.
    always_comb begin
        s_ready_x = 1'b0;
        m_valid_y = 1'b0;
        clr_acc   = 1'b0;
        addr_x    = rd_addr[ADDRX-1:0];
        addr_f    = k[ADDRF-1:0];
        case (state)
            LOAD: begin
                s_ready_x = 1'b1;
                addr_x    = wc[ADDRX-1:0];
            end
            COMPUTE: begin
                clr_acc = (k == '0);
            end
            OUT: begin
                m_valid_y = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign wr_en_x   = s_valid_x && s_ready_x;
    assign en_acc    = en_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched: directed bench for the convolution sequencer.
// A small behavioural datapath (x RAM, f ROM, accumulator) follows the DUT
// strobes. Expected results are hand-derived closed forms, queued per frame.
module tb_conv_sched;

    localparam int LENX  = 64;
    localparam int LENF  = 33;
    localparam int ADDRX = 6;
    localparam int ADDRF = 6;
    localparam int NOUT  = LENX - LENF + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic             s_valid_x;
    logic             s_ready_x;
    logic             m_valid_y;
    logic             m_ready_y;
    logic             wr_en_x;
    logic [ADDRX-1:0] addr_x;
    logic [ADDRF-1:0] addr_f;
    logic             clr_acc;
    logic             en_acc;
    logic [1:0]       fsm_state;

    conv_sched #(.LENX(LENX), .LENF(LENF), .ADDRX(ADDRX), .ADDRF(ADDRF)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid_x (s_valid_x),
        .s_ready_x (s_ready_x),
        .m_valid_y (m_valid_y),
        .m_ready_y (m_ready_y),
        .wr_en_x   (wr_en_x),
        .addr_x    (addr_x),
        .addr_f    (addr_f),
        .clr_acc   (clr_acc),
        .en_acc    (en_acc),
        .fsm_state (fsm_state)
    );

    // ---------------- datapath model ----------------
    int x_mem [LENX];
    int f_rom [64];
    int x_rd = 0;
    int f_rd = 0;
    int acc = 0;
    int s_data = 0;

    always @(posedge clk) begin
        if (wr_en_x) x_mem[addr_x] <= s_data;
        x_rd <= x_mem[addr_x];
        f_rd <= f_rom[addr_f];
        if (clr_acc) acc <= 0;
        else if (en_acc) acc <= acc + x_rd * f_rd;
    end

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    int out_count = 0;
    bit rdy_random = 1'b0;
    bit stall_armed = 1'b0;
    bit check_stall = 1'b0;
    int stall_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- downstream ready driver ----------------
    initial begin
        m_ready_y = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_armed && m_valid_y && out_count == 5) begin
                stall_cnt   = 10;
                stall_armed = 1'b0;
            end
            if (stall_cnt > 0) begin
                m_ready_y = 1'b0;
                stall_cnt--;
            end else if (rdy_random) begin
                m_ready_y = 1'($urandom_range(0, 1));
            end else begin
                m_ready_y = 1'b1;
            end
        end
    end

    // ---------------- monitor ----------------
    int ld_cnt = 0;
    int win = 0;
    int issue_k = 0;
    int cyc = 0;
    int en_cnt = 0;
    int vcnt = 0;
    int snap_ax = 0;
    int snap_af = 0;
    int snap_acc = 0;
    bit after_load = 1'b0;
    bit prev_valid = 1'b0;
    bit ready_chk = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_s_ready", int'(s_ready_x), 1);
            chk("rst_m_valid", int'(m_valid_y), 0);
            chk("rst_clr_acc", int'(clr_acc), 0);
            chk("rst_en_acc", int'(en_acc), 0);
            chk("rst_addr_x", int'(addr_x), 0);
            ld_cnt     = 0;
            win        = 0;
            issue_k    = 0;
            after_load = 1'b0;
            prev_valid = 1'b0;
            ready_chk  = 1'b0;
            out_count  = 0;
            exp_q.delete();
        end else begin
            if (ready_chk) begin
                chk("s_ready_after_frame", int'(s_ready_x), 1);
                ready_chk = 1'b0;
            end
            if (after_load) begin
                chk("load_done_s_ready", int'(s_ready_x), 0);
                chk("load_done_clr", int'(clr_acc), 1);
                chk("load_done_addr_x", int'(addr_x), 0);
                chk("load_done_addr_f", int'(addr_f), 0);
                after_load = 1'b0;
            end
            if (wr_en_x) begin
                chk("load_addr_x", int'(addr_x), ld_cnt);
                ld_cnt++;
                if (ld_cnt == LENX) begin
                    ld_cnt     = 0;
                    after_load = 1'b1;
                end
            end
            if (clr_acc) begin
                chk("win_start_addr_x", int'(addr_x), win);
                chk("win_start_addr_f", int'(addr_f), 0);
                issue_k = 1;
                cyc     = 0;
                en_cnt  = 0;
            end else if (issue_k > 0) begin
                cyc++;
                en_cnt += int'(en_acc);
                if (issue_k < LENF) begin
                    chk("issue_addr_x", int'(addr_x), win + issue_k);
                    chk("issue_addr_f", int'(addr_f), issue_k);
                    issue_k++;
                end
            end
            if (m_valid_y) begin
                chk("out_no_en_acc", int'(en_acc), 0);
                chk("out_no_clr_acc", int'(clr_acc), 0);
                if (!prev_valid) begin
                    chk("valid_latency", cyc, LENF + 1);
                    chk("en_acc_count", en_cnt, LENF);
                    issue_k  = 0;
                    snap_ax  = int'(addr_x);
                    snap_af  = int'(addr_f);
                    snap_acc = acc;
                    vcnt     = 1;
                end else begin
                    chk("hold_addr_x", int'(addr_x), snap_ax);
                    chk("hold_addr_f", int'(addr_f), snap_af);
                    chk("hold_acc", acc, snap_acc);
                    vcnt++;
                end
                if (m_ready_y) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL result_unexpected: got %0d, expected no result", acc);
                    end else begin
                        chk("result", acc, int'(exp_q.pop_front()));
                    end
                    if (check_stall && win == 5) chk("stall_valid_cycles", (vcnt >= 11) ? 1 : 0, 1);
                    out_count++;
                    win++;
                    if (win == NOUT) begin
                        win       = 0;
                        ready_chk = 1'b1;
                    end
                end
            end
            prev_valid = m_valid_y;
        end
    end

    // ---------------- driver tasks ----------------
    // kind 0: x=1; kind 1: x=i; kind 2: x=2; kind 3: x=i+1. f[j] = j+1.
    task automatic load_frame(input int kind, input bit rnd);
        int i = 0;
        int budget = 0;
        bit hs;
        while (i < LENX && budget < 4000) begin
            case (kind)
                0:       s_data = 1;
                1:       s_data = i;
                2:       s_data = 2;
                default: s_data = i + 1;
            endcase
            s_valid_x = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            hs = s_valid_x && s_ready_x;
            @(posedge clk);
            #1;
            if (hs) i++;
            budget++;
        end
        s_valid_x = 1'b0;
        if (i < LENX) begin
            checks++;
            errors++;
            $display("FAIL load_timeout: got %0d samples, expected %0d", i, LENX);
        end else begin
            for (int w = 0; w < NOUT; w++) begin
                case (kind)
                    0:       exp_q.push_back(32'(561));
                    1:       exp_q.push_back(32'(561 * w + 11968));
                    2:       exp_q.push_back(32'(1122));
                    default: exp_q.push_back(32'(561 * w + 12529));
                endcase
            end
        end
    endtask

    task automatic wait_outputs(input int target, input string name);
        int n = 0;
        while (out_count < target && n < 6000) begin
            @(posedge clk);
            n++;
        end
        if (out_count < target) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d results, expected %0d", name, out_count, target);
        end
    endtask

    task automatic frame_end_checks(input string name);
        repeat (40) @(posedge clk);
        #1;
        chk({name, "_out_count"}, out_count, NOUT);
        chk({name, "_queue_left"}, exp_q.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int j = 0; j < 64; j++) f_rom[j] = (j < LENF) ? j + 1 : 0;
        reset     = 1'b0;
        s_valid_x = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_state", int'(fsm_state), 0);
        chk("post_rst_s_ready", int'(s_ready_x), 1);
        chk("post_rst_wr_en", int'(wr_en_x), 0);
        chk("post_rst_addr_f", int'(addr_f), 0);
        chk("post_rst_m_valid", int'(m_valid_y), 0);
        @(posedge clk);
        #1;

        // Frame A: continuous load, x=1, 10-cycle stall on window 5.
        out_count   = 0;
        stall_armed = 1'b1;
        check_stall = 1'b1;
        load_frame(0, 1'b0);
        wait_outputs(NOUT, "frame_a");
        frame_end_checks("frame_a");
        check_stall = 1'b0;

        // Frame B: random valid and ready, x=i.
        out_count  = 0;
        rdy_random = 1'b1;
        load_frame(1, 1'b1);
        wait_outputs(NOUT, "frame_b");
        frame_end_checks("frame_b");
        rdy_random = 1'b0;

        // Frame C: reset in window 10 at tap 17, partial results discarded.
        out_count = 0;
        load_frame(2, 1'b0);
        wait_outputs(10, "frame_c");
        begin
            int n = 0;
            @(negedge clk);
            while (!clr_acc && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("frame_c_found_win10_clr", int'(clr_acc), 1);
        end
        repeat (17) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_state", int'(fsm_state), 0);
        chk("mid_rst_m_valid", int'(m_valid_y), 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Frame D: fresh frame after reset, x=i+1.
        out_count = 0;
        load_frame(3, 1'b0);
        wait_outputs(NOUT, "frame_d");
        frame_end_checks("frame_d");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_sched.md
# conv_sched

Sequencer for the single-lane convolution datapath: x-buffer RAM, f-coefficient ROM and saturating MAC/ReLU accumulator. It loads one frame of LENX input samples through a valid/ready slave port, then walks every output window. For each window it issues x/f read addresses, drives accumulator clear/enable aligned to the 1-cycle memory read latency, and presents each result on a valid/ready master port. It owns all control; the datapath (memories, multiplier, saturation, ReLU) sits outside and only follows its strobes.

## Interface
- LENX, 64, input samples per frame
- LENF, 33, filter taps
- ADDRX, 6, x address width (2^ADDRX ≥ LENX)
- ADDRF, 6, f address width (2^ADDRF ≥ LENF)
- clk  input  1  single clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low; asserting (0) clears all state immediately
- s_valid_x  input  1  upstream sample valid
- s_ready_x  output  1  sample accepted when s_valid_x && s_ready_x at a rising edge
- m_valid_y  output  1  result on datapath output is valid
- m_ready_y  input  1  downstream accepts result
- wr_en_x  output  1  x RAM write enable (combinational = s_valid_x && s_ready_x)
- addr_x  output  ADDRX  x RAM address (write address in LOAD, read address in COMPUTE)
- addr_f  output  ADDRF  f ROM read address
- clr_acc  output  1  synchronous clear of accumulator
- en_acc  output  1  accumulate product of current x/f read data

## Operation
- Outputs per frame NOUT = LENX−LENF+1 (32 at defaults); window w uses x[w..w+LENF−1] against f[0..LENF−1].
- States: LOAD, COMPUTE, DRAIN, OUT.
- LOAD: s_ready_x=1; addr_x = write counter wc; each handshake writes and increments wc. Handshake with wc==LENX−1 → COMPUTE, wc←0, w←0, k←0.
- COMPUTE: addr_x = w+k, addr_f = k; k increments every cycle; clr_acc=1 only in cycle k==0. At k==LENF−1 → DRAIN.
- en_acc = registered copy of "address issued in COMPUTE" (1 cycle later), so en_acc is high for exactly LENF consecutive cycles, starting the cycle after clr_acc.
- DRAIN: one cycle; last en_acc occurs here; no address issue (addr_x, addr_f held, value don't-care). → OUT.
- OUT: m_valid_y=1, held with all other outputs stable until m_ready_y=1. On handshake: if w==NOUT−1 → LOAD (wc=0); else w←w+1, k←0, → COMPUTE.
- s_ready_x=0 in every state except LOAD; no overlap of load and compute (single-port x RAM).
- Counters: wc ADDRX+1 bits, k ADDRF+1 bits, w ADDRX bits; compare against LENX−1, LENF−1, NOUT−1 exactly, no wrap.
- Address arithmetic w+k ≤ LENX−1 always; never exceeds RAM range.

## Timing
- During reset and after release: state LOAD, s_ready_x=1, m_valid_y=0, wr_en_x=0 (since s_valid_x gated by bench), addr_x=0, addr_f=0, clr_acc=0, en_acc=0.
- Reset mid-frame: immediately to LOAD, counters zeroed, partial frame discarded, m_valid_y drops asynchronously.
- Per window: COMPUTE entry cycle C → clr_acc at C, en_acc C+1..C+LENF, m_valid_y from C+LENF+1 (LENF+1 = 34 cycles at defaults).
- Output stall: no en_acc or clr_acc while m_valid_y=1; accumulator value preserved.
- After last result handshake, s_ready_x=1 in the next cycle; next frame sample may be accepted that cycle.
- First COMPUTE cycle immediately follows the cycle of the LENX-th input handshake.
- s_valid_x ignored outside LOAD; m_ready_y ignored outside OUT.

## Test plan
- Reset: hold reset=0 for 3 cycles mid-random traffic → s_ready_x=1, m_valid_y=0, clr_acc=en_acc=0, addr_x=0 during and after release.
- Continuous load: s_valid_x=1 for 64 cycles → wr_en_x with addr_x 0..63 in order; s_ready_x=0 the cycle after the 64th handshake; clr_acc=1 that cycle with addr_x=0, addr_f=0.
- Window 0 sequencing: addr_x/addr_f 0..32 on consecutive cycles; en_acc high exactly 33 cycles starting one cycle after clr_acc; m_valid_y rises 34 cycles after COMPUTE entry. With x=1 all and f as loaded, datapath sum matches golden.
- Backpressure: m_ready_y=0 for 10 cycles in window 5 → m_valid_y held 10+ cycles, addr_x/addr_f/en_acc frozen, result accepted unchanged; window 6 starts with addr_x=6.
- Full frame with random valid/ready (50%): exactly 32 output handshakes, last window reads addr_x 31..63; s_ready_x reasserts the cycle after the 32nd; second frame produces correct results.
- Reset mid-COMPUTE (window 10, k=17): next cycle state LOAD, wc=0; a fresh 64-sample frame yields 32 correct outputs with no stale result.
